// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain arbiter: grants one FIFO read side at a time for a burst
// of up to MAX_BURST words into a single shared downstream stream, then
// rotates priority to the next eligible port.
module fifo_drain_arbiter #(
  parameter int N_PORTS     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_BURST   = 8,
  parameter int GRANT_WIDTH = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [N_PORTS*DATA_WIDTH-1:0] src_data,
  input  logic [N_PORTS-1:0]            src_valid,
  output logic [N_PORTS-1:0]            src_ack,
  input  logic [N_PORTS-1:0]            port_enable,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [GRANT_WIDTH-1:0]        grant_id,
  output logic                          busy
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(MAX_BURST - 1);
  localparam logic [GRANT_WIDTH-1:0] LAST_INIT = GRANT_WIDTH'(N_PORTS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                 state;
  logic [GRANT_WIDTH-1:0] last_q;
  logic [CNT_W-1:0]       burst_cnt;

  logic [N_PORTS-1:0]     eligible;
  logic                   pick_found;
  logic [GRANT_WIDTH-1:0] pick_id;
  int                     pick_idx;
  logic                   sel_valid;
  logic                   xfer;

  assign eligible = src_valid & port_enable;

  // Round-robin search upward from last+1; scanning offsets from far to near
  // lets the nearest eligible port overwrite any farther candidate.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_idx   = 0;
    for (int k = N_PORTS; k >= 1; k--) begin
      pick_idx = (int'(last_q) + k) % N_PORTS;
      if (eligible[pick_idx]) begin
        pick_found = 1'b1;
        pick_id    = GRANT_WIDTH'(pick_idx);
      end
    end
  end

  // Route the granted source to the output; valid and ack are forced low in
  // IDLE and during reset so nothing is popped outside a live burst.
  always_comb begin
    data_out       = src_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    sel_valid      = src_valid[grant_id] & port_enable[grant_id];
    data_out_valid = (state == BURST) && !rst && sel_valid;
    xfer           = data_out_valid && data_out_ready;
    src_ack        = '0;
    src_ack[grant_id] = xfer;
  end

  // Grant FSM: one arbitration cycle in IDLE, then a burst that ends on the
  // word limit or as soon as the granted source stops presenting valid data.
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= '0;
      last_q    <= LAST_INIT;
      burst_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_id;
            burst_cnt <= '0;
            state     <= BURST;
            busy      <= 1'b1;
          end
        end
        BURST: begin
          if (!data_out_valid || (xfer && (burst_cnt == CNT_LAST))) begin
            state  <= IDLE;
            busy   <= 1'b0;
            last_q <= grant_id;
          end else if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter: four modelled source FIFOs, each
// word tagged with its port number and a per-port sequence number.
module tb_fifo_drain_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int GW = 2;

  logic             clock = 1'b0;
  logic             rst;
  logic [NP*DW-1:0] src_data;
  logic [NP-1:0]    src_valid;
  logic [NP-1:0]    src_ack;
  logic [NP-1:0]    port_enable;
  logic [DW-1:0]    data_out;
  logic             data_out_valid;
  logic             data_out_ready;
  logic [GW-1:0]    grant_id;
  logic             busy;

  int fcnt [NP];
  int fseq [NP];
  int eseq [NP];
  int tests_run    = 0;
  int tests_failed = 0;

  fifo_drain_arbiter #(
    .N_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(MB), .GRANT_WIDTH(GW)
  ) dut (
    .clock(clock), .rst(rst),
    .src_data(src_data), .src_valid(src_valid), .src_ack(src_ack),
    .port_enable(port_enable),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input int p, input int s);
    return {8'(p), 24'(s)};
  endfunction

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      src_valid[i]          = (fcnt[i] != 0);
      src_data[i*DW +: DW]  = word(i, fseq[i]);
    end
  endtask

  // Advance one clock: pops follow the ack seen just before the edge.
  task automatic tick();
    logic [NP-1:0] pop;
    pop = src_ack;
    chk("ack_onehot", 64'($countones(src_ack) <= 1), 64'd1);
    @(posedge clock);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (pop[i]) begin
        fcnt[i]--;
        fseq[i]++;
      end
    end
    drive();
    #1;
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  task automatic reset_dut();
    rst            = 1'b1;
    data_out_ready = 1'b1;
    port_enable    = 4'hF;
    for (int i = 0; i < NP; i++) fcnt[i] = 0;
    settle();
    chk("rst_ack", 64'(src_ack), 64'd0);
    chk("rst_dov", 64'(data_out_valid), 64'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
  endtask

  // One idle arbitration cycle followed by a full MB-word burst from port p.
  task automatic run_burst(input int p);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_ack", 64'(src_ack), 64'd0);
    tick();
    for (int n = 0; n < MB; n++) begin
      chk("burst_grant", 64'(grant_id), 64'(p));
      chk("burst_busy", 64'(busy), 64'd1);
      chk("burst_ack", 64'(src_ack), 64'(1 << p));
      chk("burst_data", 64'(data_out), 64'(word(p, eseq[p])));
      eseq[p]++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    data_out_ready = 1'b1;
    port_enable = 4'hF;
    src_valid = '0;
    src_data = '0;
    for (int i = 0; i < NP; i++) begin
      fcnt[i] = 0;
      fseq[i] = 0;
      eseq[i] = 0;
    end

    // All ports valid: grants 0,1,2,3,0 with one idle cycle between bursts
    reset_dut();
    for (int i = 0; i < NP; i++) fcnt[i] = 100;
    settle();
    run_burst(0);
    run_burst(1);
    run_burst(2);
    run_burst(3);
    run_burst(0);

    // Only port 2 with 3 entries, then ports 1 and 3 appear
    reset_dut();
    fcnt[2] = 3;
    settle();
    chk("p2_idle_busy", 64'(busy), 64'd0);
    tick();
    for (int n = 0; n < 3; n++) begin
      chk("p2_grant", 64'(grant_id), 64'd2);
      chk("p2_ack", 64'(src_ack), 64'h4);
      chk("p2_data", 64'(data_out), 64'(word(2, eseq[2])));
      eseq[2]++;
      tick();
    end
    chk("p2_drain_dov", 64'(data_out_valid), 64'd0);
    chk("p2_drain_ack", 64'(src_ack), 64'd0);
    chk("p2_drain_busy", 64'(busy), 64'd1);
    tick();
    chk("p2_back_idle", 64'(busy), 64'd0);
    chk("p2_grant_hold", 64'(grant_id), 64'd2);
    fcnt[1] = 2;
    fcnt[3] = 2;
    settle();
    tick();
    chk("p2_next_grant", 64'(grant_id), 64'd3);
    chk("p2_next_ack", 64'(src_ack), 64'h8);

    // Backpressure on port 1: ready 1,0,0,1 then finish the burst
    reset_dut();
    fcnt[1] = 20;
    settle();
    tick();
    chk("bp_grant", 64'(grant_id), 64'd1);
    chk("bp_ack0", 64'(src_ack), 64'h2);
    eseq[1]++;
    tick();
    data_out_ready = 1'b0;
    settle();
    chk("bp_stall1_ack", 64'(src_ack), 64'd0);
    chk("bp_stall1_dov", 64'(data_out_valid), 64'd1);
    chk("bp_stall1_data", 64'(data_out), 64'(word(1, eseq[1])));
    tick();
    chk("bp_stall2_ack", 64'(src_ack), 64'd0);
    chk("bp_stall2_data", 64'(data_out), 64'(word(1, eseq[1])));
    tick();
    data_out_ready = 1'b1;
    settle();
    chk("bp_ack3", 64'(src_ack), 64'h2);
    chk("bp_data3", 64'(data_out), 64'(word(1, eseq[1])));
    eseq[1]++;
    tick();
    for (int n = 0; n < MB - 2; n++) begin
      chk("bp_rest_ack", 64'(src_ack), 64'h2);
      eseq[1]++;
      tick();
    end
    chk("bp_end_busy", 64'(busy), 64'd0);
    chk("bp_end_ack", 64'(src_ack), 64'd0);
    chk("bp_pops", 64'(fcnt[1]), 64'd12);

    // Port 2 disabled: sequence 0,1,3,0
    reset_dut();
    port_enable = 4'b1011;
    for (int i = 0; i < NP; i++) fcnt[i] = 100;
    settle();
    run_burst(0);
    run_burst(1);
    run_burst(3);
    run_burst(0);
    port_enable = 4'hF;

    // Disable port 0 after 3 words of its burst
    reset_dut();
    for (int i = 0; i < NP; i++) fcnt[i] = 100;
    settle();
    tick();
    for (int n = 0; n < 3; n++) begin
      chk("dis_ack", 64'(src_ack), 64'h1);
      eseq[0]++;
      tick();
    end
    port_enable = 4'b1110;
    settle();
    chk("dis_cut_ack", 64'(src_ack), 64'd0);
    chk("dis_cut_dov", 64'(data_out_valid), 64'd0);
    chk("dis_cut_busy", 64'(busy), 64'd1);
    tick();
    chk("dis_idle_busy", 64'(busy), 64'd0);
    chk("dis_idle_grant", 64'(grant_id), 64'd0);
    tick();
    chk("dis_next_grant", 64'(grant_id), 64'd1);
    chk("dis_next_ack", 64'(src_ack), 64'h2);
    chk("dis_p0_pops", 64'(fcnt[0]), 64'd97);
    port_enable = 4'hF;

    // Reset mid-burst at count 5 on port 1
    reset_dut();
    for (int i = 0; i < NP; i++) fcnt[i] = 100;
    settle();
    run_burst(0);
    tick();
    chk("mr_grant", 64'(grant_id), 64'd1);
    for (int n = 0; n < 5; n++) begin
      chk("mr_ack", 64'(src_ack), 64'h2);
      eseq[1]++;
      tick();
    end
    rst = 1'b1;
    settle();
    chk("mr_rst_ack", 64'(src_ack), 64'd0);
    chk("mr_rst_dov", 64'(data_out_valid), 64'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_grant0", 64'(grant_id), 64'd0);
    chk("mr_ack_idle", 64'(src_ack), 64'd0);
    chk("mr_p1_pops", 64'(fcnt[1]), 64'd95);
    tick();
    chk("mr_first_grant", 64'(grant_id), 64'd0);
    chk("mr_first_ack", 64'(src_ack), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
